// File: rtl/arb_pkg.sv
// Shared types and defaults for the table-memory arbiter.
//   arb_state_e   : access sequencer states
//   DEF_NUM_REQ   : default number of requesters
//   DEF_MAX_LOCK  : default number of locked beats before a forced release
package arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT,
    ARB_DONE
  } arb_state_e;

  localparam int DEF_NUM_REQ  = 4;
  localparam int DEF_MAX_LOCK = 16;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin pick.
// The request vector is scanned starting at ptr and wrapping upward. The
// first set bit wins.
//   req   : request vector
//   ptr   : index with the highest priority this cycle
//   gnt   : one-hot winner, zero when nothing is requested
//   valid : a winner exists
module rr_picker #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          valid
);

  logic [PW-1:0] idx;

  // NOTE: every variable written here gets a default before any branch,
  // otherwise a path that skips the assignment infers a latch.
  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(ptr) + i) % N);
      if (!valid && req[idx]) begin
        gnt[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter for the single flow-table memory port.
// Only one access is outstanding at a time. The memory read latency is
// fixed. A requester may lock the grant for multi-beat sequences, and a
// starvation guard limits how long that lock can be held.
//   clk, rst                       : clock, synchronous active-low reset
//   req_i/lock_i/we_i              : per-requester request, lock, write flag
//   addr_i/width_i/wdata_i         : per-requester access fields
//   gnt_o                          : one-hot current owner
//   ack_o                          : one-cycle completion pulse
//   rdata_o                        : read data, held until the next read ack
//   busy_o                         : sequencer is not idle
//   mem_ce_o/we_o/addr_o/width_o/data_o, mem_data_i : memory port
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MEM_LAT  = 1,
  parameter int MAX_LOCK = DEF_MAX_LOCK
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_i,
  input  logic [NUM_REQ-1:0]              lock_i,
  input  logic [NUM_REQ-1:0]              we_i,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]  addr_i,
  input  logic [NUM_REQ-1:0][3:0]         width_i,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]  wdata_i,
  output logic [NUM_REQ-1:0]              gnt_o,
  output logic [NUM_REQ-1:0]              ack_o,
  output logic [DATA_W-1:0]               rdata_o,
  output logic                            busy_o,
  output logic                            mem_ce_o,
  output logic                            mem_we_o,
  output logic [ADDR_W-1:0]               mem_addr_o,
  output logic [3:0]                      mem_width_o,
  output logic [DATA_W-1:0]               mem_data_o,
  input  logic [DATA_W-1:0]               mem_data_i
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = $clog2(MAX_LOCK + 1);
  localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  arb_state_e          state, state_n;
  logic [PW-1:0]       ptr_q, owner_q, owner_nxt, pick_ptr, win_idx;
  logic                locked_q;
  logic [BW-1:0]       beats_q;
  logic [LW-1:0]       lat_q;
  logic [NUM_REQ-1:0]  gnt_q, pick_req, pick_gnt;
  logic                pick_valid, wait_done, owner_drop;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [3:0]          width_q;
  logic [DATA_W-1:0]   wdata_q, rdata_q;

  assign owner_nxt  = (owner_q == PW'(NUM_REQ - 1)) ? '0 : owner_q + PW'(1);
  assign owner_drop = locked_q && !req_i[owner_q];
  assign wait_done  = (int'(lat_q) >= MEM_LAT - 1);

  // While locked, only the owner competes. If the owner has dropped its
  // request, the lock ends in this IDLE cycle and the scan starts past it.
  always_comb begin
    pick_req = req_i;
    pick_ptr = ptr_q;
    if (locked_q) begin
      if (req_i[owner_q]) begin
        pick_req          = '0;
        pick_req[owner_q] = 1'b1;
      end else begin
        pick_ptr = owner_nxt;
      end
    end
  end

  rr_picker #(.N(NUM_REQ), .PW(PW)) u_pick (
    .req   (pick_req),
    .ptr   (pick_ptr),
    .gnt   (pick_gnt),
    .valid (pick_valid)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_gnt[i]) win_idx = PW'(i);
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      ARB_IDLE:  if (pick_valid) state_n = ARB_ISSUE;
      ARB_ISSUE: state_n = (we_q || MEM_LAT == 0) ? ARB_DONE : ARB_WAIT;
      ARB_WAIT:  if (wait_done) state_n = ARB_DONE;
      ARB_DONE:  state_n = ARB_IDLE;
      default:   state_n = ARB_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // The latched fields drive the memory port directly. They are cleared
      // here so that every output reads zero during reset.
      state    <= ARB_IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      locked_q <= 1'b0;
      beats_q  <= '0;
      lat_q    <= '0;
      gnt_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      width_q  <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state <= state_n;
      unique case (state)
        ARB_IDLE: begin
          if (owner_drop) begin
            locked_q <= 1'b0;
            beats_q  <= '0;
            ptr_q    <= owner_nxt;
            gnt_q    <= '0;
          end
          if (pick_valid) begin
            gnt_q   <= pick_gnt;
            owner_q <= win_idx;
            we_q    <= we_i[win_idx];
            addr_q  <= addr_i[win_idx];
            width_q <= width_i[win_idx];
            wdata_q <= wdata_i[win_idx];
          end
        end
        ARB_ISSUE: begin
          lat_q <= '0;
          if (MEM_LAT == 0 && !we_q) rdata_q <= mem_data_i;
        end
        ARB_WAIT: begin
          if (wait_done) rdata_q <= mem_data_i;
          else           lat_q   <= lat_q + LW'(1);
        end
        ARB_DONE: begin
          if (lock_i[owner_q] && beats_q < BW'(MAX_LOCK)) begin
            locked_q <= 1'b1;
            beats_q  <= beats_q + BW'(1);
          end else begin
            locked_q <= 1'b0;
            beats_q  <= '0;
            ptr_q    <= owner_nxt;
            gnt_q    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign gnt_o       = gnt_q;
  assign ack_o       = (state == ARB_DONE) ? gnt_q : '0;
  assign rdata_o     = rdata_q;
  assign busy_o      = (state != ARB_IDLE);
  assign mem_ce_o    = (state == ARB_ISSUE);
  assign mem_we_o    = (state == ARB_ISSUE) && we_q;
  assign mem_addr_o  = addr_q;
  assign mem_width_o = width_q;
  assign mem_data_o  = wdata_q;

  // The owner must hold its request from the grant through the ack cycle.
  req_held_a: assert property (@(posedge clk) disable iff (!rst)
    (state != ARB_IDLE) |-> req_i[owner_q]);

  gnt_onehot_a: assert property (@(posedge clk) disable iff (!rst)
    $onehot0(gnt_q));

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // DUT with MEM_LAT=1
  logic [3:0]        req_i, lock_i, we_i;
  logic [3:0][31:0]  addr_i, wdata_i;
  logic [3:0][3:0]   width_i;
  logic [3:0]        gnt_o, ack_o;
  logic [31:0]       rdata_o, mem_addr_o, mem_data_o;
  logic              busy_o, mem_ce_o, mem_we_o;
  logic [3:0]        mem_width_o;
  logic [31:0]       mem_rd;

  mem_arbiter #(.NUM_REQ(4), .ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .MAX_LOCK(16)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .lock_i(lock_i), .we_i(we_i),
    .addr_i(addr_i), .width_i(width_i), .wdata_i(wdata_i),
    .gnt_o(gnt_o), .ack_o(ack_o), .rdata_o(rdata_o), .busy_o(busy_o),
    .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_width_o(mem_width_o), .mem_data_o(mem_data_o), .mem_data_i(mem_rd)
  );

  // DUT with MEM_LAT=0 and a combinational memory
  logic [3:0]        z_req, z_lock, z_we;
  logic [3:0][31:0]  z_addr, z_wdata;
  logic [3:0][3:0]   z_width;
  logic [3:0]        z_gnt, z_ack;
  logic [31:0]       z_rdata, z_mem_addr, z_mem_data, z_mem_rd;
  logic              z_busy, z_mem_ce, z_mem_we;
  logic [3:0]        z_mem_width;

  mem_arbiter #(.NUM_REQ(4), .ADDR_W(32), .DATA_W(32), .MEM_LAT(0), .MAX_LOCK(16)) dut_z (
    .clk(clk), .rst(rst), .req_i(z_req), .lock_i(z_lock), .we_i(z_we),
    .addr_i(z_addr), .width_i(z_width), .wdata_i(z_wdata),
    .gnt_o(z_gnt), .ack_o(z_ack), .rdata_o(z_rdata), .busy_o(z_busy),
    .mem_ce_o(z_mem_ce), .mem_we_o(z_mem_we), .mem_addr_o(z_mem_addr),
    .mem_width_o(z_mem_width), .mem_data_o(z_mem_data), .mem_data_i(z_mem_rd)
  );

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    if (a == 32'h40) return 32'hDEAD_BEEF;
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  // One-cycle read latency; outside valid read data the bus carries junk
  // so a wrong sampling cycle shows up.
  always @(posedge clk) begin
    if (mem_ce_o && !mem_we_o) mem_rd <= mem_f(mem_addr_o);
    else                       mem_rd <= 32'hBAD0_0000 ^ 32'(cyc);
  end
  assign z_mem_rd = mem_f(z_mem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  typedef struct {
    int          idx;
    logic        we;
    logic [3:0]  w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          t;     // IDLE cycle the request is seen in, -1 = untimed
  } exp_t;

  exp_t sb[$];

  task automatic push(input int idx, input logic we, input logic [3:0] w,
                      input logic [31:0] addr, input logic [31:0] wd, input int t);
    exp_t e;
    e.idx = idx; e.we = we; e.w = w; e.addr = addr; e.wdata = wd;
    e.rdata = we ? 32'h0 : mem_f(addr);
    e.t = t;
    sb.push_back(e);
  endtask

  // Monitor: compares each memory issue and each ack against the queue head.
  logic prev_ce = 1'b0;
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (mem_ce_o) begin
        check("ce_overlap", 32'(prev_ce), 32'h0);
        if (sb.size() == 0) begin
          check("ce_unexpected", 32'(mem_ce_o), 32'h0);
        end else begin
          check("mem_addr", mem_addr_o, sb[0].addr);
          check("mem_we", 32'(mem_we_o), 32'(sb[0].we));
          check("mem_width", 32'(mem_width_o), 32'(sb[0].w));
          if (sb[0].we) check("mem_wdata", mem_data_o, sb[0].wdata);
          if (sb[0].t >= 0) check("ce_cycle", 32'(cyc), 32'(sb[0].t + 1));
        end
      end
      if (ack_o != 4'h0) begin
        if (sb.size() == 0) begin
          check("ack_unexpected", 32'(ack_o), 32'h0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("ack_owner", 32'(ack_o), 32'h1 << e.idx);
          check("gnt_at_ack", 32'(gnt_o), 32'(ack_o));
          if (!e.we) check("rdata", rdata_o, e.rdata);
          if (e.t >= 0) check("ack_cycle", 32'(cyc), 32'(e.t + (e.we ? 2 : 3)));
        end
      end
      prev_ce = mem_ce_o;
    end else begin
      prev_ce = 1'b0;
    end
  end

  task automatic drive(input int idx, input int n, input logic we, input logic [3:0] w,
                       input logic [31:0] base, input logic [31:0] wd, input logic lk);
    for (int k = 0; k < n; k++) begin
      int waited;
      we_i[idx]    = we;
      width_i[idx] = w;
      addr_i[idx]  = base + 32'(4 * k);
      wdata_i[idx] = wd + 32'(k);
      lock_i[idx]  = lk;
      req_i[idx]   = 1'b1;
      waited = 0;
      do begin
        @(negedge clk);
        waited++;
      end while (!ack_o[idx] && waited < 300);
      if (!ack_o[idx]) check("ack_timeout", 32'(ack_o[idx]), 32'h1);
      @(posedge clk); #1;
    end
    req_i[idx]  = 1'b0;
    lock_i[idx] = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy_o), 32'h0);
    check({tag, "_gnt"}, 32'(gnt_o), 32'h0);
    check({tag, "_ack"}, 32'(ack_o), 32'h0);
    check({tag, "_rdata"}, rdata_o, 32'h0);
    check({tag, "_ce"}, 32'(mem_ce_o), 32'h0);
    check({tag, "_mem_we"}, 32'(mem_we_o), 32'h0);
    check({tag, "_mem_addr"}, mem_addr_o, 32'h0);
    check({tag, "_mem_width"}, 32'(mem_width_o), 32'h0);
    check({tag, "_mem_data"}, mem_data_o, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    rst = 1'b0;
    req_i = '0; lock_i = '0; we_i = '0; addr_i = '0; width_i = '0; wdata_i = '0;
    z_req = '0; z_lock = '0; z_we = '0; z_addr = '0; z_width = '0; z_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero_outputs("reset");
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;

    // Single read, requester 0
    push(0, 1'b0, 4'd4, 32'h40, 32'h0, cyc);
    drive(0, 1, 1'b0, 4'd4, 32'h40, 32'h0, 1'b0);

    // Single write, requester 2
    push(2, 1'b1, 4'd4, 32'h80, 32'h1234_5678, cyc);
    drive(2, 1, 1'b1, 4'd4, 32'h80, 32'h1234_5678, 1'b0);

    // Byte read, requester 3: leaves the pointer at 0
    push(3, 1'b0, 4'd1, 32'h30, 32'h0, cyc);
    drive(3, 1, 1'b0, 4'd1, 32'h30, 32'h0, 1'b0);

    // All four requesting: order 0,1,2,3,0, one read every 4 cycles
    t0 = cyc;
    push(0, 1'b0, 4'd4, 32'h1000, 32'h0, t0);
    push(1, 1'b0, 4'd4, 32'h1100, 32'h0, t0 + 4);
    push(2, 1'b0, 4'd4, 32'h1200, 32'h0, t0 + 8);
    push(3, 1'b0, 4'd4, 32'h1300, 32'h0, t0 + 12);
    push(0, 1'b0, 4'd4, 32'h1004, 32'h0, t0 + 16);
    fork
      drive(0, 2, 1'b0, 4'd4, 32'h1000, 32'h0, 1'b0);
      drive(1, 1, 1'b0, 4'd4, 32'h1100, 32'h0, 1'b0);
      drive(2, 1, 1'b0, 4'd4, 32'h1200, 32'h0, 1'b0);
      drive(3, 1, 1'b0, 4'd4, 32'h1300, 32'h0, 1'b0);
    join
    repeat (3) @(posedge clk);
    #1;

    // Requester 1 locks for 20 reads; forced release after 17, then 3 gets in
    for (int k = 0; k < 17; k++) push(1, 1'b0, 4'd4, 32'h100 + 32'(4 * k), 32'h0, -1);
    push(3, 1'b0, 4'd4, 32'h300, 32'h0, -1);
    for (int k = 17; k < 20; k++) push(1, 1'b0, 4'd4, 32'h100 + 32'(4 * k), 32'h0, -1);
    fork
      drive(1, 20, 1'b0, 4'd4, 32'h100, 32'h0, 1'b1);
      drive(3, 1, 1'b0, 4'd4, 32'h300, 32'h0, 1'b0);
    join
    repeat (3) @(posedge clk);
    #1;

    // Owner 1 dropped its request while locked: pointer is 2, so 0 beats 1
    push(0, 1'b1, 4'd1, 32'h500, 32'hA5, -1);
    push(1, 1'b1, 4'd2, 32'h504, 32'hBEEF, -1);
    fork
      drive(0, 1, 1'b1, 4'd1, 32'h500, 32'hA5, 1'b0);
      drive(1, 1, 1'b1, 4'd2, 32'h504, 32'hBEEF, 1'b0);
    join
    repeat (2) @(posedge clk);
    #1;

    // Reset during WAIT: access abandoned, no ack, pointer back to 0
    t0 = cyc;
    push(2, 1'b0, 4'd4, 32'h200, 32'h0, t0);
    we_i[2] = 1'b0; width_i[2] = 4'd4; addr_i[2] = 32'h200; req_i[2] = 1'b1;
    @(posedge clk); #1;          // ISSUE
    @(posedge clk); #1;          // WAIT
    rst = 1'b0;
    @(posedge clk); #1;
    req_i[2] = 1'b0;
    @(negedge clk);
    check_zero_outputs("mid_reset");
    sb.delete();
    @(posedge clk); #1 rst = 1'b1;
    push(1, 1'b0, 4'd4, 32'h210, 32'h0, -1);
    push(3, 1'b0, 4'd4, 32'h310, 32'h0, -1);
    fork
      drive(1, 1, 1'b0, 4'd4, 32'h210, 32'h0, 1'b0);
      drive(3, 1, 1'b0, 4'd4, 32'h310, 32'h0, 1'b0);
    join

    // MEM_LAT=0: data sampled in ISSUE, ack at t+2
    @(posedge clk); #1;
    z_we[0] = 1'b0; z_width[0] = 4'd4; z_addr[0] = 32'h44; z_req[0] = 1'b1;
    @(negedge clk);              // cycle t
    @(negedge clk);              // cycle t+1
    check("z_ce", 32'(z_mem_ce), 32'h1);
    check("z_mem_addr", z_mem_addr, 32'h44);
    check("z_no_early_ack", 32'(z_ack), 32'h0);
    @(negedge clk);              // cycle t+2
    check("z_ack", 32'(z_ack), 32'h1);
    check("z_rdata", z_rdata, mem_f(32'h44));
    @(posedge clk); #1 z_req[0] = 1'b0;

    repeat (5) @(posedge clk);
    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
